// File: rtl/cache_fill_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_unit_if
// Description : Pipeline/memory/data-array signal bundle for cache_fill_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_fill_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_address;
    logic [DATA_W-1:0] wr_data;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_data_in;
    logic              fsm_busy;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_out;
    logic [ADDR_W-1:0] fill_address;
    logic              write_data_array;
    logic              write_tag_array;

    modport master (
        output miss_detected, miss_address, wr_req, wr_address, wr_data,
               mem_data_valid, mem_data_in,
        input  fsm_busy, stall, mem_req, mem_we, mem_address, mem_data_out,
               fill_address, write_data_array, write_tag_array
    );

    modport slave (
        input  miss_detected, miss_address, wr_req, wr_address, wr_data,
               mem_data_valid, mem_data_in,
        output fsm_busy, stall, mem_req, mem_we, mem_address, mem_data_out,
               fill_address, write_data_array, write_tag_array
    );
endinterface
`default_nettype wire

// File: rtl/cache_fill_unit.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_unit
// Description : Block-fill controller with write-through store forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_unit #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic               clk,
    input  logic               rst,
    cache_fill_unit_if.slave   bus
);
    localparam int BYTES   = DATA_W / 8;
    localparam int RX_W    = $clog2(WORDS_PER_BLOCK);
    localparam int ISSUE_W = RX_W + 1;

    localparam logic [ADDR_W-1:0]  c_BYTES       = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0]  c_OFFSET_MASK = ADDR_W'(WORDS_PER_BLOCK * BYTES - 1);
    localparam logic [ISSUE_W-1:0] c_ISSUE_END   = ISSUE_W'(WORDS_PER_BLOCK);
    localparam logic [RX_W-1:0]    c_LAST_RX     = RX_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [ISSUE_W-1:0]  r_issueCnt;
    logic [RX_W-1:0]     r_rxCnt;

    logic w_busy;
    logic w_issuing;

    assign w_busy    = (r_state == S_FILL);
    assign w_issuing = (r_issueCnt < c_ISSUE_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_issueCnt <= '0;
            r_rxCnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.miss_detected) begin
                        r_state    <= S_FILL;
                        r_base     <= bus.miss_address & ~c_OFFSET_MASK;
                        r_issueCnt <= '0;
                        r_rxCnt    <= '0;
                    end
                end
                S_FILL: begin
                    if (w_issuing) begin
                        r_issueCnt <= r_issueCnt + 1'b1;
                    end
                    // The final returned word closes the fill; the edge after it is IDLE.
                    if (bus.mem_data_valid) begin
                        if (r_rxCnt == c_LAST_RX) begin
                            r_state    <= S_IDLE;
                            r_issueCnt <= '0;
                            r_rxCnt    <= '0;
                        end else begin
                            r_rxCnt <= r_rxCnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs are gated by rst so they drop the moment reset rises.
    always_comb begin
        bus.fsm_busy         = 1'b0;
        bus.stall            = 1'b0;
        bus.mem_req          = 1'b0;
        bus.mem_we           = 1'b0;
        bus.mem_address      = '0;
        bus.mem_data_out     = '0;
        bus.fill_address     = '0;
        bus.write_data_array = 1'b0;
        bus.write_tag_array  = 1'b0;
        if (!rst) begin
            bus.fsm_busy = w_busy;
            bus.stall    = bus.miss_detected | w_busy;
            if (w_busy) begin
                if (w_issuing) begin
                    bus.mem_req     = 1'b1;
                    bus.mem_address = r_base + ADDR_W'(r_issueCnt) * c_BYTES;
                end
                bus.fill_address = r_base + ADDR_W'(r_rxCnt) * c_BYTES;
                if (bus.mem_data_valid) begin
                    bus.write_data_array = 1'b1;
                    bus.write_tag_array  = (r_rxCnt == c_LAST_RX);
                end
            end else if (bus.wr_req && !bus.miss_detected) begin
                bus.mem_req      = 1'b1;
                bus.mem_we       = 1'b1;
                bus.mem_address  = bus.wr_address;
                bus.mem_data_out = bus.wr_data;
            end
        end
    end
endmodule
`default_nettype wire
